// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: time/rank widths, leaderboard depth and the
// ranker FSM state encoding.
package stopwatch_pkg;

  localparam int TIME_W   = 23;
  localparam int LB_DEPTH = 5;
  localparam int RANK_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    WRITE,
    DONE
  } lb_state_t;

endpackage

// File: rtl/leaderboard_ranker_if.sv
// Leaderboard ranker bus: result submission, clear, display read port and
// rank reporting. master = stopwatch/display side, slave = ranker.
interface leaderboard_ranker_if #(
  parameter int TIME_W = stopwatch_pkg::TIME_W,
  parameter int RANK_W = stopwatch_pkg::RANK_W
);

  logic [TIME_W-1:0] time_in;
  logic              time_valid;
  logic              clear;
  logic [RANK_W-1:0] rd_idx;
  logic [TIME_W-1:0] rd_time;
  logic              rd_valid;
  logic [RANK_W-1:0] rank;
  logic              rank_valid;
  logic              busy;

  modport master (
    output time_in, time_valid, clear, rd_idx,
    input  rd_time, rd_valid, rank, rank_valid, busy
  );

  modport slave (
    input  time_in, time_valid, clear, rd_idx,
    output rd_time, rd_valid, rank, rank_valid, busy
  );

endinterface

// File: rtl/leaderboard_ranker.sv
// Sorted top-DEPTH lap-time table: inserts each finished time in ascending
// order one entry per cycle and reports its rank (0 = not placed).
module leaderboard_ranker #(
  parameter int TIME_W = stopwatch_pkg::TIME_W,
  parameter int DEPTH  = stopwatch_pkg::LB_DEPTH,
  parameter int RANK_W = stopwatch_pkg::RANK_W
) (
  input logic                 clock,
  input logic                 reset,
  leaderboard_ranker_if.slave lb
);

  import stopwatch_pkg::*;

  localparam logic [RANK_W-1:0] LAST_IDX = RANK_W'(DEPTH - 1);

  lb_state_t state_reg, state_next;

  logic [TIME_W-1:0] cand_reg;
  logic [RANK_W-1:0] idx_reg;
  logic [RANK_W-1:0] pos_reg;
  logic [RANK_W-1:0] k_reg;
  logic [RANK_W-1:0] rank_reg;
  logic [TIME_W-1:0] rd_time_reg;
  logic              rd_valid_reg;

  logic [TIME_W-1:0] ent_time_reg  [DEPTH];
  logic              ent_valid_reg [DEPTH];

  logic              load, advance, place, miss, shift_en, write_en;
  logic [TIME_W-1:0] scan_time;
  logic              scan_valid;
  logic [RANK_W-1:0] valid_cnt;
  logic [RANK_W-1:0] shift_start;
  logic [TIME_W-1:0] rd_time_next;
  logic              rd_valid_next;

  always_comb begin
    scan_time     = '0;
    scan_valid    = 1'b0;
    valid_cnt     = '0;
    rd_time_next  = '0;
    rd_valid_next = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (idx_reg == RANK_W'(j)) begin
        scan_time  = ent_time_reg[j];
        scan_valid = ent_valid_reg[j];
      end
      if (lb.rd_idx == RANK_W'(j)) begin
        rd_time_next  = ent_time_reg[j];
        rd_valid_next = ent_valid_reg[j];
      end
      valid_cnt = valid_cnt + RANK_W'(ent_valid_reg[j]);
    end
    // Valid entries always form a prefix, so slots above the fill level hold
    // invalid zeros and need no shifting; start at the first empty slot.
    shift_start = (valid_cnt > LAST_IDX) ? LAST_IDX : valid_cnt;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    place      = 1'b0;
    miss       = 1'b0;
    shift_en   = 1'b0;
    write_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lb.time_valid) begin
          if (lb.time_in == '0) begin
            miss       = 1'b1;
            state_next = DONE;
          end else begin
            load       = 1'b1;
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (!scan_valid || cand_reg < scan_time) begin
          place      = 1'b1;
          state_next = SHIFT;
        end else if (idx_reg == LAST_IDX) begin
          miss       = 1'b1;
          state_next = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      SHIFT: begin
        if (k_reg > pos_reg) shift_en = 1'b1;
        else                 state_next = WRITE;
      end
      WRITE: begin
        write_en   = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (lb.clear) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_reg <= '0;
      idx_reg  <= '0;
      pos_reg  <= '0;
      k_reg    <= '0;
      rank_reg <= '0;
    end else if (lb.clear) begin
      rank_reg <= '0;
    end else begin
      if (load) begin
        cand_reg <= lb.time_in;
        idx_reg  <= '0;
      end
      if (advance)  idx_reg <= idx_reg + RANK_W'(1);
      if (place) begin
        pos_reg <= idx_reg;
        k_reg   <= shift_start;
      end
      if (shift_en) k_reg    <= k_reg - RANK_W'(1);
      if (write_en) rank_reg <= pos_reg + RANK_W'(1);
      if (miss)     rank_reg <= '0;
    end
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam int PREV = (gi == 0) ? 0 : gi - 1;
    // Entry 0 is never a shift target (k > pos >= 0), so PREV=0 is never used there.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        ent_time_reg[gi]  <= '0;
        ent_valid_reg[gi] <= 1'b0;
      end else if (lb.clear) begin
        ent_time_reg[gi]  <= '0;
        ent_valid_reg[gi] <= 1'b0;
      end else if (write_en && pos_reg == RANK_W'(gi)) begin
        ent_time_reg[gi]  <= cand_reg;
        ent_valid_reg[gi] <= 1'b1;
      end else if (shift_en && k_reg == RANK_W'(gi)) begin
        ent_time_reg[gi]  <= ent_time_reg[PREV];
        ent_valid_reg[gi] <= ent_valid_reg[PREV];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_time_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_time_reg  <= rd_time_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign lb.rd_time    = rd_time_reg;
  assign lb.rd_valid   = rd_valid_reg;
  assign lb.rank       = rank_reg;
  assign lb.rank_valid = (state_reg == DONE);
  assign lb.busy       = (state_reg != IDLE);

endmodule
